// File: rtl/riscv_pkg.sv
// Shared HPM constants, used by the event shaper and the counter block.
package riscv_pkg;
  localparam int HPM_NUM_EVENTS    = 28;
  localparam int HPM_INC_WIDTH     = 2;
  localparam int HPM_BACKLOG_WIDTH = 4;

  // Largest value a backlog counter of the given width can hold.
  function automatic int backlog_max(input int width);
    return (1 << width) - 1;
  endfunction
endpackage

// File: rtl/hpm_event_lane.sv
// One event lane: folds a multi-valued increment into a backlog that
// drains as at most one pulse per cycle, saturating and flagging loss.
module hpm_event_lane
  import riscv_pkg::*;
#(
  parameter int INC_WIDTH     = HPM_INC_WIDTH,
  parameter int BACKLOG_WIDTH = HPM_BACKLOG_WIDTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [INC_WIDTH-1:0]     inc_i,
  output logic                     event_o,
  output logic                     lost_o,
  output logic [BACKLOG_WIDTH-1:0] backlog_o
);
  localparam int SW = BACKLOG_WIDTH + 1;
  localparam logic [SW-1:0] SAT = SW'(backlog_max(BACKLOG_WIDTH));

  logic [BACKLOG_WIDTH-1:0] backlog_q, backlog_d;
  logic                     event_d, lost_d;
  logic [SW-1:0]            sum, dec;

  // Next backlog / pulse / loss; clear overrides everything.
  always_comb begin
    sum       = {1'b0, backlog_q} + (enable_i ? SW'(inc_i) : '0);
    dec       = sum - SW'(1);
    backlog_d = '0;
    event_d   = 1'b0;
    lost_d    = lost_o;
    if (clear_i) begin
      lost_d = 1'b0;
    end else if (sum != '0) begin
      event_d = 1'b1;
      if (dec > SAT) begin
        backlog_d = SAT[BACKLOG_WIDTH-1:0];
        lost_d    = 1'b1;
      end else begin
        backlog_d = dec[BACKLOG_WIDTH-1:0];
      end
    end
  end

  // Lane state; reset drops any in-flight backlog.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      backlog_q <= '0;
      event_o   <= 1'b0;
      lost_o    <= 1'b0;
    end else begin
      backlog_q <= backlog_d;
      event_o   <= event_d;
      lost_o    <= lost_d;
    end
  end

  assign backlog_o = backlog_q;
endmodule

// File: rtl/hpm_event_shaper.sv
// Shapes per-lane multi-issue event counts into single-bit pulses for the
// HPM counter block. Lanes are fully independent.
module hpm_event_shaper
  import riscv_pkg::*;
#(
  parameter int HPM_NUM_EVENTS = riscv_pkg::HPM_NUM_EVENTS,
  parameter int INC_WIDTH      = HPM_INC_WIDTH,
  parameter int BACKLOG_WIDTH  = HPM_BACKLOG_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  enable_i,
  input  logic                                  clear_i,
  input  logic [HPM_NUM_EVENTS:1][INC_WIDTH-1:0] event_inc_i,
  output logic [HPM_NUM_EVENTS:1]               events_o,
  output logic [HPM_NUM_EVENTS:1]               lost_o,
  output logic                                  busy_o
);
  // A narrower backlog could not absorb one full-cycle increment.
  if (BACKLOG_WIDTH < INC_WIDTH) begin : g_width_chk
    $error("hpm_event_shaper: BACKLOG_WIDTH must be >= INC_WIDTH");
  end

  logic [HPM_NUM_EVENTS:1][BACKLOG_WIDTH-1:0] backlog;

  for (genvar e = 1; e <= HPM_NUM_EVENTS; e++) begin : g_lane
    hpm_event_lane #(
      .INC_WIDTH    (INC_WIDTH),
      .BACKLOG_WIDTH(BACKLOG_WIDTH)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .enable_i (enable_i),
      .clear_i  (clear_i),
      .inc_i    (event_inc_i[e]),
      .event_o  (events_o[e]),
      .lost_o   (lost_o[e]),
      .backlog_o(backlog[e])
    );
  end

  // Busy while any lane still has pulses queued.
  always_comb begin
    busy_o = 1'b0;
    for (int e = 1; e <= HPM_NUM_EVENTS; e++)
      busy_o = busy_o | (backlog[e] != '0);
  end
endmodule

// File: tb/tb_hpm_event_shaper.sv
// Self-checking bench for hpm_event_shaper with an event-count reference model.
module tb_hpm_event_shaper;
  localparam int N   = 28;
  localparam int IW  = 2;
  localparam int CAP = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en  = 1'b0;
  logic                 clr = 1'b0;
  logic [N:1][IW-1:0]   inc = '0;
  logic [N:1]           events_o, lost_o;
  logic                 busy_o;

  int checks = 0;
  int errors = 0;

  // Model: pending events per lane, plus expected pulse and loss flags.
  int pend [1:N];
  bit m_ev [1:N];
  bit m_lost [1:N];

  hpm_event_shaper dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (en),
    .clear_i    (clr),
    .event_inc_i(inc),
    .events_o   (events_o),
    .lost_o     (lost_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int e = 1; e <= N; e++) begin
      pend[e] = 0; m_ev[e] = 0; m_lost[e] = 0;
    end
  endtask

  // Count-conservation view: every accepted event becomes one pulse, queued
  // events beyond CAP are lost.
  task automatic model_step();
    for (int e = 1; e <= N; e++) begin
      if (clr) begin
        pend[e] = 0; m_ev[e] = 0; m_lost[e] = 0;
      end else begin
        int total;
        total = pend[e] + (en ? int'(inc[e]) : 0);
        m_ev[e] = (total > 0);
        if (total > 0) total = total - 1;
        if (total > CAP) begin
          total = CAP; m_lost[e] = 1;
        end
        pend[e] = total;
      end
    end
  endtask

  // One clock: inputs already driven at negedge; check at following negedge.
  task automatic cycle(input string tag);
    logic [N:1] xev, xlost;
    logic xbusy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    xbusy = 1'b0;
    for (int e = 1; e <= N; e++) begin
      xev[e] = m_ev[e]; xlost[e] = m_lost[e];
      if (pend[e] != 0) xbusy = 1'b1;
    end
    checks++;
    if (events_o !== xev) begin
      errors++; $display("FAIL %s events_o got %h want %h", tag, events_o, xev);
    end
    checks++;
    if (lost_o !== xlost) begin
      errors++; $display("FAIL %s lost_o got %h want %h", tag, lost_o, xlost);
    end
    checks++;
    if (busy_o !== xbusy) begin
      errors++; $display("FAIL %s busy_o got %b want %b", tag, busy_o, xbusy);
    end
  endtask

  task automatic idle(input int n, input string tag);
    inc = '0;
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; inc = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (events_o !== '0 || lost_o !== '0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL reset outputs got ev=%h lost=%h busy=%b want 0", events_o, lost_o, busy_o);
    end
    rst = 1'b0;
    model_reset();
    idle(2, "reset_idle");
  endtask

  task automatic test_burst();
    logic [4:1] evs, bsy;
    inc = '0; inc[5] = 2'd3; en = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cycle("burst");
      inc = '0;
      evs[c] = events_o[5]; bsy[c] = busy_o;
    end
    checks++;
    if (evs !== 4'b0111) begin
      errors++; $display("FAIL burst_pulses got %b want 0111 (c4..c1)", evs);
    end
    checks++;
    if (bsy !== 4'b0011) begin
      errors++; $display("FAIL burst_busy got %b want 0011 (c4..c1)", bsy);
    end
  endtask

  task automatic test_sustained();
    int cnt = 0;
    inc = '0; inc[1] = 2'd1;
    for (int c = 0; c < 20; c++) begin
      cycle("sustained");
      if (events_o[1]) cnt++;
    end
    checks++;
    if (cnt != 20 || busy_o !== 1'b0 || lost_o[1] !== 1'b0) begin
      errors++; $display("FAIL sustained got pulses=%0d busy=%b lost=%b want 20/0/0", cnt, busy_o, lost_o[1]);
    end
    idle(2, "sustained_tail");
  endtask

  task automatic test_saturation();
    int cnt = 0;
    inc = '0; inc[2] = 2'd3;
    for (int c = 0; c < 8; c++) cycle("sat_fill");
    checks++;
    if (lost_o[2] !== 1'b1 || pend[2] != CAP) begin
      errors++; $display("FAIL sat_lost got lost=%b pend=%0d want 1/15", lost_o[2], pend[2]);
    end
    inc = '0;
    for (int c = 0; c < 20; c++) begin
      cycle("sat_drain");
      if (events_o[2]) cnt++;
    end
    checks++;
    if (cnt != CAP || lost_o[2] !== 1'b1) begin
      errors++; $display("FAIL sat_drain got pulses=%0d lost=%b want 15/1", cnt, lost_o[2]);
    end
  endtask

  task automatic test_clear();
    inc = '0; inc[3] = 2'd3;
    for (int c = 0; c < 3; c++) cycle("clr_fill");
    inc[3] = 2'd2; clr = 1'b1;
    cycle("clr_hit");
    clr = 1'b0; inc = '0;
    checks++;
    if (events_o[3] !== 1'b0 || busy_o !== 1'b0 || lost_o !== '0) begin
      errors++; $display("FAIL clear_prio got ev3=%b busy=%b lost=%h want 0/0/0", events_o[3], busy_o, lost_o);
    end
    idle(3, "clr_after");
  endtask

  task automatic test_enable_gating();
    int cnt = 0;
    inc = '0; inc[4] = 2'd3;
    for (int c = 0; c < 2; c++) cycle("gate_fill");
    en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cycle("gate_off");
      if (events_o[4]) cnt++;
    end
    checks++;
    if (cnt != 4 || lost_o[4] !== 1'b0 || events_o[4] !== 1'b0) begin
      errors++; $display("FAIL gate got pulses=%0d lost=%b last=%b want 4/0/0", cnt, lost_o[4], events_o[4]);
    end
    en = 1'b1;
    idle(2, "gate_tail");
  endtask

  task automatic test_async_reset();
    int cnt = 0;
    inc = '0; inc[6] = 2'd3;
    for (int c = 0; c < 3; c++) cycle("ar_fill");
    inc = '0;
    cycle("ar_drain");
    #2 rst = 1'b1;
    #1;
    checks++;
    if (events_o !== '0 || busy_o !== 1'b0 || lost_o !== '0) begin
      errors++; $display("FAIL async_reset got ev=%h busy=%b lost=%h want 0", events_o, busy_o, lost_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      cycle("ar_after");
      if (events_o[6]) cnt++;
    end
    checks++;
    if (cnt != 0) begin
      errors++; $display("FAIL async_reset_release got pulses=%0d want 0", cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int e = 1; e <= N; e++)
        inc[e] = ($urandom_range(0, 2) == 0) ? IW'($urandom_range(0, 3)) : '0;
      en  = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 39) == 0);
      cycle("random");
    end
    en = 1'b1; clr = 1'b0;
    idle(20, "random_drain");
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_burst();
    test_sustained();
    test_saturation();
    clr = 1'b1; cycle("flush"); clr = 1'b0;
    test_clear();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hpm_event_shaper.md
HPM_EVENT_SHAPER -- requirements
Module: hpm_event_shaper

Interface
REQ-001 SHALL have parameter HPM_NUM_EVENTS, default 28, number of event lanes, indexed 1..HPM_NUM_EVENTS.
REQ-002 SHALL have parameter INC_WIDTH, default 2, width of the per-lane per-cycle increment (0..3).
REQ-003 SHALL have parameter BACKLOG_WIDTH, default 4, width of the per-lane backlog counter (max 15).
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port enable_i, input, 1, global increment accept; when 0, increments are ignored.
REQ-007 SHALL have port clear_i, input, 1, synchronous flush of all backlog and lost flags.
REQ-008 SHALL have port event_inc_i, input, HPM_NUM_EVENTS x INC_WIDTH packed array [HPM_NUM_EVENTS:1], event count per lane this cycle from a multi-issue core.
REQ-009 SHALL have port events_o, output, HPM_NUM_EVENTS, vector [HPM_NUM_EVENTS:1] of single-bit pulses to the HPM counter block events_i.
REQ-010 SHALL have port lost_o, output, HPM_NUM_EVENTS, per-lane sticky flag indicating dropped events.
REQ-011 SHALL have port busy_o, output, 1, high when any lane backlog is nonzero.

Function
REQ-012 SHALL convert each lane's multi-valued increment stream into at most one events_o pulse per lane per cycle, preserving total count unless saturated.
REQ-013 SHALL compute per lane: sum = backlog_q + (enable_i ? event_inc_i[e] : 0), at width BACKLOG_WIDTH+1.
REQ-014 SHALL, when sum > 0, register events_o[e] = 1 for the next cycle and set backlog_d = sum - 1; otherwise set events_o[e] = 0 and backlog_d = 0.
REQ-015 SHALL, when sum - 1 exceeds 2^BACKLOG_WIDTH - 1, saturate backlog_d to 2^BACKLOG_WIDTH - 1 and set lost_o[e] to 1.
REQ-016 SHALL register events_o, giving one-cycle latency from the first increment to the first pulse.
REQ-017 SHALL continue draining backlog while enable_i = 0; only new increments are dropped, and lost_o is not set for dropped increments.
REQ-018 SHALL, when clear_i = 1, zero all backlogs, zero events_o and lost_o the next cycle, and discard same-cycle increments; clear_i takes priority over all other inputs.
REQ-019 SHALL keep lost_o sticky until clear_i or reset.
REQ-020 SHALL drive busy_o combinationally as the OR over lanes of (backlog_q != 0).
REQ-021 SHALL treat lanes independently, with no cross-lane arbitration.

Reset
REQ-022 SHALL, on rst_i assertion, immediately clear all backlog counters, events_o, and lost_o to 0, regardless of clk_i.
REQ-023 SHALL discard in-flight backlog on reset mid-drain; the first pulse after release requires a new increment.

Structure
REQ-024 SHALL place default constants HPM_NUM_EVENTS, HPM_INC_WIDTH, and HPM_BACKLOG_WIDTH in riscv_pkg, shared with the counter block.
REQ-025 SHALL implement one lane as sub-module hpm_event_lane (backlog, pulse, and lost registers), generate-instantiated HPM_NUM_EVENTS times; the top level holds only the busy_o OR-reduction.
REQ-026 SHALL emit an elaboration error if BACKLOG_WIDTH < INC_WIDTH.

Verification
REQ-027 SHALL cover burst: lane 5 inc = 3 in cycle 0 only, enable = 1 -> events_o[5] high in cycles 1, 2, 3; low in cycle 4; busy_o high in cycles 1-2.
REQ-028 SHALL cover sustained load: lane 1 inc = 1 every cycle for 20 cycles -> events_o[1] high in cycles 1-20, backlog stays 0, lost_o[1] = 0.
REQ-029 SHALL cover saturation: lane 2 inc = 3 for 8 cycles -> backlog reaches 15 with lost_o[2] = 1, followed by exactly 15 drain pulses after input stops.
REQ-030 SHALL cover clear priority: lane 3 backlog 6 and inc = 2 with clear_i = 1 -> next cycle events_o[3] = 0, busy_o = 0, lost_o = 0.
REQ-031 SHALL cover enable gating: backlog 4, enable_i = 0, inc = 3 for 10 cycles -> exactly 4 pulses, then silence; lost_o stays 0.
REQ-032 SHALL cover async reset: rst_i asserted between clock edges mid-drain -> events_o and busy_o go 0 immediately; no pulses after release without new input.
